uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_arb_pkg.sv | 20 ++
 rtl/rr_picker.sv | 27 ++
 rtl/uart_tx_arbiter.sv | 161 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding,
// parameter defaults and a width helper used by the top and the picker.
package uart_arb_pkg;

  localparam int N_REQ_DEFAULT     = 3;
  localparam int BUSY_WAIT_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_HI = 2'd2,
    WAIT_LO = 2'd3
  } arb_state_e;

  // Index width that stays at least one bit wide for degenerate sizes.
  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin selector: returns a one-hot grant for the first
// asserted request at or after the pointer, wrapping past the top index.
module rr_picker #(
  parameter int N  = 3,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o
);

  always_comb begin
    logic found;
    int   idx;
    gnt_o = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr_i) + k) % N;
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Arbitrates several byte-stream requesters onto a single uart_tx, keeping a
// multi-byte message contiguous and guarding against a uart that never responds.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ     = N_REQ_DEFAULT,
  parameter int BUSY_WAIT = BUSY_WAIT_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic               tx_start,
  output logic [7:0]         tx_byte,
  input  logic               tx_busy,
  output logic [N_REQ-1:0]   grant,
  output logic               busy_timeout
);

  localparam int PW = idxWidth(N_REQ);
  localparam int CW = idxWidth(BUSY_WAIT + 1);

  arb_state_e state_q, state_d;
  logic [7:0]    byte_q, byte_d;
  logic [PW-1:0] owner_q, owner_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic          locked_q, locked_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [N_REQ-1:0] owner_oh;
  logic [N_REQ-1:0] elig_req;
  logic [N_REQ-1:0] pick_gnt;
  logic [PW-1:0]    pick_idx;
  logic [7:0]       pick_byte;
  logic             pick_last;
  logic             accept;
  logic             wait_expired;

  always_comb begin
    owner_oh = '0;
    for (int i = 0; i < N_REQ; i++) begin
      owner_oh[i] = (owner_q == PW'(i));
    end
  end

  // While a message is open only its owner may compete, so the picker just echoes it.
  assign elig_req = req_valid & (locked_q ? owner_oh : {N_REQ{1'b1}});

  rr_picker #(
    .N  (N_REQ),
    .PW (PW)
  ) u_picker (
    .req_i (elig_req),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt)
  );

  always_comb begin
    pick_idx  = '0;
    pick_byte = '0;
    pick_last = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_gnt[i]) begin
        pick_idx  = PW'(i);
        pick_byte = req_data[8*i +: 8];
        pick_last = req_last[i];
      end
    end
  end

  assign accept       = (state_q == IDLE) && !tx_busy && (|pick_gnt);
  assign wait_expired = (cnt_q == CW'(BUSY_WAIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ISSUE;
      ISSUE:   state_d = WAIT_HI;
      WAIT_HI: begin
        if (tx_busy) begin
          state_d = WAIT_LO;
        end else if (wait_expired) begin
          state_d = IDLE;
        end
      end
      WAIT_LO: if (!tx_busy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready    = '0;
    tx_start     = 1'b0;
    busy_timeout = 1'b0;
    grant        = '0;
    case (state_q)
      IDLE: begin
        if (accept) req_ready = pick_gnt;
        if (locked_q) grant = owner_oh;
      end
      ISSUE: begin
        tx_start = 1'b1;
        grant    = owner_oh;
      end
      WAIT_HI: begin
        grant        = owner_oh;
        busy_timeout = !tx_busy && wait_expired;
      end
      WAIT_LO: grant = owner_oh;
      default: grant = '0;
    endcase
  end

  assign tx_byte = byte_q;

  // Lock and pointer only move at acceptance; a timeout does not end a message.
  always_comb begin
    byte_d   = byte_q;
    owner_d  = owner_q;
    locked_d = locked_q;
    ptr_d    = ptr_q;
    cnt_d    = (state_q == WAIT_HI) ? cnt_q + 1'b1 : '0;
    if (accept) begin
      byte_d  = pick_byte;
      owner_d = pick_idx;
      if (pick_last) begin
        locked_d = 1'b0;
        ptr_d    = (pick_idx == PW'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
      end else begin
        locked_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_q   <= '0;
      owner_q  <= '0;
      locked_q <= 1'b0;
      ptr_q    <= '0;
      cnt_q    <= '0;
    end else begin
      byte_q   <= byte_d;
      owner_q  <= owner_d;
      locked_q <= locked_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queue-driven requesters, a simple uart_tx model
// and a per-cycle reference model of the arbitration rules.
module tb_uart_tx_arbiter;

  localparam int N     = 3;
  localparam int BW    = 4;
  localparam int FRAME = 10;

  logic             clk;
  logic             rst_n;
  logic [N-1:0]     req_valid;
  logic [8*N-1:0]   req_data;
  logic [N-1:0]     req_last;
  logic [N-1:0]     req_ready;
  logic             tx_start;
  logic [7:0]       tx_byte;
  logic             tx_busy;
  logic [N-1:0]     grant;
  logic             busy_timeout;

  uart_tx_arbiter #(.N_REQ(N), .BUSY_WAIT(BW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .tx_start     (tx_start),
    .tx_byte      (tx_byte),
    .tx_busy      (tx_busy),
    .grant        (grant),
    .busy_timeout (busy_timeout)
  );

  typedef struct {
    logic [7:0] b;
    bit         last;
  } item_t;

  item_t      srcQ[N][$];
  logic [7:0] emitted[$];
  int         acceptCnt[N];
  int         acceptCyc[N];
  int         tests = 0;
  int         failures = 0;
  int         cyc = 0;
  int         lastStartCyc = 0;
  int         timeoutDelta = -1;
  int         timeoutCnt = 0;
  int         busyFallCyc = -1;
  int         uartMode = 0;
  bit         busyManual = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic [7:0] b, input bit last);
    item_t it;
    it.b    = b;
    it.last = last;
    srcQ[idx].push_back(it);
  endtask

  function automatic int rrWinner(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] oneHot(input int i);
    logic [N-1:0] r;
    r = '0;
    if (i >= 0) r[i] = 1'b1;
    return r;
  endfunction

  function automatic logic [31:0] emittedAt(input int k);
    if (k < emitted.size()) return {24'h0, emitted[k]};
    return 32'hDEAD;
  endfunction

  // Requesters: each queue presents its head byte and drops it once accepted.
  initial begin
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    forever begin : srcLoop
      logic [N-1:0] acc;
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (acc[i] && srcQ[i].size() > 0) srcQ[i].delete(0);
        if (srcQ[i].size() > 0) begin
          req_valid[i]       = 1'b1;
          req_data[8*i +: 8] = srcQ[i][0].b;
          req_last[i]        = srcQ[i][0].last;
        end else begin
          req_valid[i]       = 1'b0;
          req_data[8*i +: 8] = 8'h00;
          req_last[i]        = 1'b0;
        end
      end
    end
  end

  // uart_tx model: mode 0 busy for FRAME cycles after a start, 1 never busy, 2 manual.
  initial begin : uartModel
    int cnt;
    bit st;
    cnt     = 0;
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      st = tx_start;
      @(posedge clk);
      #1;
      case (uartMode)
        0: begin
          if (st) cnt = FRAME;
          tx_busy = (cnt > 0);
          if (cnt > 0) cnt--;
        end
        1: begin
          tx_busy = 1'b0;
          cnt     = 0;
        end
        default: begin
          if (tx_busy && !busyManual) busyFallCyc = cyc;
          tx_busy = busyManual;
          cnt     = 0;
        end
      endcase
    end
  end

  // Reference model of the arbitration rules, compared against the DUT every cycle.
  initial begin : refModel
    bit         mInflight, mIssue, mSawBusy, mLocked;
    int         mWait, mOwner, mPtr, mCur, w;
    logic [7:0] mByte;
    logic [N-1:0] elig;
    mInflight = 0; mIssue = 0; mSawBusy = 0; mLocked = 0;
    mWait = 0; mOwner = 0; mPtr = 0; mCur = 0; mByte = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mInflight = 0; mIssue = 0; mSawBusy = 0; mLocked = 0;
        mWait = 0; mOwner = 0; mPtr = 0; mCur = 0; mByte = 8'h00;
      end else begin
        if (tx_start) begin
          emitted.push_back(tx_byte);
          lastStartCyc = cyc;
        end
        if (busy_timeout) begin
          timeoutDelta = cyc - lastStartCyc;
          timeoutCnt++;
        end
        for (int i = 0; i < N; i++) begin
          if (req_valid[i] && req_ready[i]) begin
            acceptCnt[i]++;
            acceptCyc[i] = cyc;
          end
        end
        checkOutput("readyOnehot", {31'h0, $onehot0(req_ready)}, 1);
        checkOutput("txByte", tx_byte, mByte);
        if (!mInflight) begin
          elig = mLocked ? (req_valid & oneHot(mOwner)) : req_valid;
          w    = tx_busy ? -1 : rrWinner(elig, mPtr);
          checkOutput("idleReady", req_ready, oneHot(w));
          checkOutput("idleStart", tx_start, 0);
          checkOutput("idleTimeout", busy_timeout, 0);
          checkOutput("idleGrant", grant, mLocked ? oneHot(mOwner) : '0);
          if (w >= 0) begin
            mInflight = 1; mIssue = 1; mSawBusy = 0; mWait = 0; mCur = w;
            mByte = req_data[8*w +: 8];
            if (req_last[w]) begin
              mLocked = 0;
              mPtr    = (w + 1) % N;
            end else begin
              mLocked = 1;
              mOwner  = w;
            end
          end
        end else begin
          checkOutput("busyReady", req_ready, 0);
          checkOutput("busyGrant", grant, oneHot(mCur));
          if (mIssue) begin
            checkOutput("issueStart", tx_start, 1);
            checkOutput("issueTimeout", busy_timeout, 0);
            mIssue = 0;
          end else if (!mSawBusy) begin
            checkOutput("waitStart", tx_start, 0);
            if (tx_busy) begin
              mSawBusy = 1;
              checkOutput("waitTimeout", busy_timeout, 0);
            end else begin
              mWait++;
              checkOutput("waitTimeout", busy_timeout, (mWait == BW) ? 1 : 0);
              if (mWait == BW) mInflight = 0;
            end
          end else begin
            checkOutput("drainStart", tx_start, 0);
            checkOutput("drainTimeout", busy_timeout, 0);
            if (!tx_busy) mInflight = 0;
          end
        end
      end
    end
  end

  task automatic syncNeg();
    @(negedge clk);
    #1;
  endtask

  task automatic settle(input int c);
    repeat (c) syncNeg();
  endtask

  task automatic waitEmitted(input int n, input int budget);
    int k = 0;
    while (emitted.size() < n && k < budget) begin
      syncNeg();
      k++;
    end
    checkOutput("waitEmitted", {31'h0, emitted.size() >= n}, 1);
  endtask

  task automatic waitAccept(input int idx, input int n, input int budget);
    int k = 0;
    while (acceptCnt[idx] < n && k < budget) begin
      syncNeg();
      k++;
    end
    checkOutput("waitAccept", {31'h0, acceptCnt[idx] >= n}, 1);
  endtask

  task automatic applyReset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int base, base2, a, tc;
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) begin
      acceptCnt[i] = 0;
      acceptCyc[i] = -1;
    end
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rstReady", req_ready, 0);
    checkOutput("rstStart", tx_start, 0);
    checkOutput("rstByte", tx_byte, 0);
    checkOutput("rstGrant", grant, 0);
    checkOutput("rstTimeout", busy_timeout, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single byte from requester 0.
    syncNeg();
    base = emitted.size();
    applyStimulus(0, 8'h42, 1);
    waitEmitted(base + 1, 50);
    checkOutput("singleByte", emittedAt(base), 32'h42);
    settle(FRAME + 6);
    checkOutput("singleGrantIdle", grant, 0);
    checkOutput("singleAcceptCnt", acceptCnt[0], 1);

    // Three simultaneous single-byte messages from pointer 0, then wrap check.
    applyReset();
    syncNeg();
    base = emitted.size();
    applyStimulus(0, 8'h10, 1);
    applyStimulus(1, 8'h20, 1);
    applyStimulus(2, 8'h30, 1);
    waitEmitted(base + 3, 100);
    checkOutput("rrFirst", emittedAt(base), 32'h10);
    checkOutput("rrSecond", emittedAt(base + 1), 32'h20);
    checkOutput("rrThird", emittedAt(base + 2), 32'h30);
    settle(FRAME + 6);
    base2 = emitted.size();
    applyStimulus(1, 8'h21, 1);
    applyStimulus(0, 8'h11, 1);
    waitEmitted(base2 + 2, 100);
    checkOutput("rrWrapFirst", emittedAt(base2), 32'h11);
    checkOutput("rrWrapSecond", emittedAt(base2 + 1), 32'h21);

    // 16-byte banner with requester 0 arriving mid-message.
    settle(FRAME + 6);
    base = emitted.size();
    a    = acceptCnt[2];
    for (int i = 0; i < 16; i++) applyStimulus(2, 8'hB0 + 8'(i), i == 15);
    waitAccept(2, a + 3, 100);
    checkOutput("bannerGrant", grant, 3'b100);
    applyStimulus(0, 8'h41, 1);
    waitEmitted(base + 17, 800);
    for (int i = 0; i < 16; i++) checkOutput("bannerByte", emittedAt(base + i), 32'hB0 + i);
    checkOutput("bannerThenCipher", emittedAt(base + 16), 32'h41);

    // uart never raises busy: timeout 4 cycles after each start.
    settle(FRAME + 6);
    uartMode = 1;
    base = emitted.size();
    tc   = timeoutCnt;
    applyStimulus(1, 8'h55, 1);
    applyStimulus(1, 8'h66, 1);
    waitEmitted(base + 2, 100);
    settle(8);
    checkOutput("timeoutByte0", emittedAt(base), 32'h55);
    checkOutput("timeoutByte1", emittedAt(base + 1), 32'h66);
    checkOutput("timeoutCount", timeoutCnt - tc, 2);
    checkOutput("timeoutDelay", timeoutDelta, BW);
    uartMode = 0;

    // Reset during the drain of a locked message.
    settle(8);
    base = emitted.size();
    a    = acceptCnt[2];
    applyStimulus(2, 8'hC1, 0);
    applyStimulus(2, 8'hC2, 0);
    applyStimulus(2, 8'hC3, 1);
    waitAccept(2, a + 1, 50);
    applyStimulus(0, 8'h77, 1);
    waitEmitted(base + 1, 20);
    settle(4);
    checkOutput("lockGrantBeforeRst", grant, 3'b100);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("midRstGrant", grant, 0);
    checkOutput("midRstStart", tx_start, 0);
    checkOutput("midRstReady", req_ready, 0);
    checkOutput("midRstByte", tx_byte, 0);
    checkOutput("midRstTimeout", busy_timeout, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    base2 = emitted.size();
    waitEmitted(base2 + 3, 200);
    checkOutput("lockedFirstByte", emittedAt(base), 32'hC1);
    checkOutput("afterRstFirst", emittedAt(base2), 32'h77);
    checkOutput("afterRstSecond", emittedAt(base2 + 1), 32'hC2);
    checkOutput("afterRstThird", emittedAt(base2 + 2), 32'hC3);

    // tx_busy held high in IDLE: acceptance on the first low cycle.
    settle(FRAME + 6);
    uartMode   = 2;
    busyManual = 1;
    settle(2);
    base = emitted.size();
    a    = acceptCnt[1];
    applyStimulus(1, 8'h99, 1);
    settle(6);
    checkOutput("busyHoldNoAccept", acceptCnt[1], a);
    checkOutput("busyHoldNoStart", emitted.size(), base);
    busyManual = 0;
    waitAccept(1, a + 1, 20);
    checkOutput("busyFallAccept", acceptCyc[1], busyFallCyc);
    waitEmitted(base + 1, 20);
    checkOutput("busyFallByte", emittedAt(base), 32'h99);
    settle(10);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
